// File: rtl/psum_rd_sched_if.sv
// Read-port bundle between the psum read-out scheduler and the 3-bank psum RAM.
// The scheduler drives mode, strobe and address; the RAM consumes them.
interface psum_rd_sched_if #(
    parameter int AW = 9
);
    logic          read_data_mode;
    logic          read_1line_req;
    logic [AW-1:0] read_1line_addr;

    modport master (
        output read_data_mode,
        output read_1line_req,
        output read_1line_addr
    );

    modport slave (
        input  read_data_mode,
        input  read_1line_req,
        input  read_1line_addr
    );
endinterface

// File: rtl/psum_rd_sched.sv
// One-line read-out scheduler for the 3-bank psum RAM: walks an N x N map row-major,
// one address per accepted cycle, and returns a valid strobe aligned with the RAM data.
module psum_rd_sched #(
    parameter int AW         = 9,
    parameter int RD_LATENCY = 4
) (
    input  logic            s_clk,
    input  logic            s_rst,
    input  logic            code_valid,
    input  logic [15:0]     conv_img_size,
    input  logic            i_start,
    input  logic            i_ready,
    psum_rd_sched_if.master ram,
    output logic            o_data_valid,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);
    localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_size;
    logic [15:0]           r_n;
    logic [15:0]           r_row;
    logic [15:0]           r_col;
    logic [1:0]            r_row_mod;
    logic [AW-1:0]         r_base;
    logic [DW-1:0]         r_drain_cnt;
    logic                  r_err;
    logic [RD_LATENCY-1:0] r_vld_sr;
    logic [RD_LATENCY-1:0] w_vld_sr_next;
    logic [15:0]           w_n_start;
    logic [31:0]           w_n32;
    logic [31:0]           w_groups;
    logic                  w_size_bad;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_col_last;
    logic                  w_last;
    logic                  w_mode;

    // Frame fits only if every bank holds ceil(N/3) rows of N pixels within 2^AW words.
    assign w_n_start  = r_size - 16'd2;
    assign w_n32      = {16'd0, w_n_start};
    assign w_groups   = (w_n32 + 32'd2) / 32'd3;
    assign w_size_bad = (r_size < 16'd3) || ((w_groups * w_n32) > (32'd1 << AW));

    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_issue    = (r_state == S_RUN) && i_ready;
    assign w_col_last = (r_col == (r_n - 16'd1));
    assign w_last     = w_issue && w_col_last && (r_row == (r_n - 16'd1));

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mode       = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = w_size_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_mode = 1'b1;
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_mode = 1'b1;
                o_busy = 1'b1;
                if (r_drain_cnt == DW'(RD_LATENCY - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_size      <= '0;
            r_n         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_row_mod   <= '0;
            r_base      <= '0;
            r_drain_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (code_valid) begin
                r_size <= conv_img_size;
            end
            if (w_accept) begin
                r_n         <= w_n_start;
                r_row       <= '0;
                r_col       <= '0;
                r_row_mod   <= '0;
                r_base      <= '0;
                r_drain_cnt <= '0;
                r_err       <= w_size_bad;
            end else if (w_issue) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                    // Every third row lands back in bank 0, one N-wide slot further down.
                    if (r_row_mod == 2'd2) begin
                        r_row_mod <= 2'd0;
                        r_base    <= r_base + r_n[AW-1:0];
                    end else begin
                        r_row_mod <= r_row_mod + 2'd1;
                    end
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end
            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_vld
            if (gi == 0) begin : g_head
                assign w_vld_sr_next[gi] = w_issue;
            end else begin : g_tail
                assign w_vld_sr_next[gi] = r_vld_sr[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr <= w_vld_sr_next;
        end
    end

    assign ram.read_data_mode  = w_mode;
    assign ram.read_1line_req  = w_issue;
    assign ram.read_1line_addr = r_base + r_col[AW-1:0];
    assign o_data_valid        = r_vld_sr[RD_LATENCY-1];
    assign o_err               = r_err;
endmodule
